shift_unit: RTL and testbench
=============================

# shift_unit

Parametrised multi-cycle shifter for the ALU: LSL, LSR, ASR and ROR on a WIDTH-bit operand, with optional [N, Z, C, V] flag update. Each cycle shifts by at most STEP positions, trading latency for area. Operands enter and results leave through valid/ready handshakes, so the unit sits beside the single-cycle ALU ops and stalls issue only when it is busy.

## Interface
- WIDTH, 32, operand/result width (≥2)
- STEP, 4, maximum shift positions per cycle (1..WIDTH)
- AMT_W, 8, shift-amount input width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  request present
- start_ready  out  1  unit can accept (high only in IDLE)
- op  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- operand  in  WIDTH  value to shift
- amount  in  AMT_W  shift count, unsigned
- s  in  1  1 = update flags, 0 = pass flag_in through
- flag_in  in  4  current flags {N,Z,C,V}
- result  out  WIDTH  shifted value
- flag_out  out  4  new flags {N,Z,C,V}
- done_valid  out  1  result/flag_out valid
- done_ready  in  1  consumer takes result

## Operation
- States:
  - IDLE: start_ready=1. On start_valid, accept and latch op, operand, s and flag_in; compute eff; go to SHIFT.
  - SHIFT: shift by min(rem, STEP); rem -= that; go to DONE when the pre-step rem ≤ STEP.
  - DONE: done_valid=1. On done_ready, go to IDLE.
- eff at accept:
  - LSL/LSR/ASR: min(amount, WIDTH+1). The result is identical beyond that.
  - ROR: amount mod WIDTH. If amount≠0 and the mod gives 0, result = operand and C = operand[MSB].
- Fill: LSL/LSR fill with 0; ASR fills with operand[MSB]; ROR wraps.
- Carry (C) is the last bit shifted out. For ROR, C = result[MSB].
  - LSL by WIDTH → C = operand[0]; by >WIDTH → C = 0.
  - LSR by WIDTH → C = operand[MSB]; by >WIDTH → C = 0.
  - ASR by ≥WIDTH → result all sign bits, C = sign.
- amount = 0: result = operand and C is unchanged (flag_in C).
- Flags:
  - s=1: N = result[MSB]; Z = (result==0); C as above; V = flag_in V.
  - s=0: flag_out = latched flag_in.
- start_valid is ignored outside IDLE.

## Timing
- Reset values: IDLE; result=0; flag_out=0; done_valid=0; start_ready=1; internal registers=0.
- Accept at edge k → done_valid high after edge k + max(1, ceil(eff/STEP)).
- While done_valid=1 and done_ready=0, result and flag_out are held stable.
- done_valid falls on the edge after done_ready=1. start_ready rises in that same cycle. Back-to-back throughput is therefore one op per latency+2 cycles.
- rst_n low at any time, including mid-SHIFT or in DONE, immediately forces the reset values. The in-flight op is lost.
- start_ready and done_valid are decoded directly from the state register, with no combinational path from inputs.

## Structure
- Package shift_pkg holds:
  - op encoding enum (LSL/LSR/ASR/ROR)
  - flag bit indices N=3, Z=2, C=1, V=0
  - state enum (IDLE/SHIFT/DONE)
- Sub-module shift_step: combinational; shifts by n ≤ STEP for a given op and returns {value, carry_out}. It is instantiated once and the top FSM iterates over it.

## Test plan
(WIDTH=32, STEP=4)
- LSL 3 by 1, s=1, flag_in=0000 → result 6, flag_out 0000, done_valid 1 cycle after accept.
- LSL 0xFFFFFFFF by 9, s=1 → result 0xFFFFFE00, flag_out 1010, done_valid after 3 cycles.
- ASR 0xFFFFFFFA by 4, s=0, flag_in=1010 → result 0xFFFFFFFF, flag_out 1010.
- LSL 1 by 32, s=1 → result 0, flag_out 0110, latency 8. LSL 1 by 40 → result 0, flag_out 0100, latency 9. Amount 0 with flag_in 0010 → result = operand, C stays 1.
- ROR 0x80000001:
  - by 36 → result 0x18000000, C=0.
  - by 32 → result 0x80000001, C=1.
- Handshake and reset:
  - Hold done_ready=0 for 3 cycles → result stable, start_ready 0, a pulsed start_valid is ignored.
  - Drop rst_n mid-SHIFT → IDLE, done_valid 0, result 0, start_ready 1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle ALU shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Bit positions inside the {N,Z,C,V} flag nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/shift_step.sv
// One combinational shift pass of up to STEP positions; the top iterates it.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int CNT_W = $clog2(STEP + 1)
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] value,
    input  logic [CNT_W-1:0] n,
    input  logic             carry_in,
    output logic [WIDTH-1:0] value_out,
    output logic             carry_out
);

    // Double-width scratch so the last bit shifted out lands at a fixed index.
    logic [2*WIDTH-1:0] wide;

    // Shift by n; with n == 0 the value and carry pass through untouched.
    always_comb begin
        wide      = '0;
        value_out = value;
        carry_out = carry_in;
        if (n != '0) begin
            case (shift_op_t'(op))
                OP_LSL: begin
                    wide      = {{WIDTH{1'b0}}, value} << n;
                    value_out = wide[WIDTH-1:0];
                    carry_out = wide[WIDTH];
                end
                OP_LSR: begin
                    wide      = {value, {WIDTH{1'b0}}} >> n;
                    value_out = wide[2*WIDTH-1:WIDTH];
                    carry_out = wide[WIDTH-1];
                end
                OP_ASR: begin
                    wide      = $signed({value, {WIDTH{1'b0}}}) >>> n;
                    value_out = wide[2*WIDTH-1:WIDTH];
                    carry_out = wide[WIDTH-1];
                end
                default: begin
                    // Rotate: low half of {v,v} >> n; carry mirrors the new MSB.
                    wide      = {value, value} >> n;
                    value_out = wide[WIDTH-1:0];
                    carry_out = wide[WIDTH-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR unit with {N,Z,C,V} flag update and
// valid/ready handshakes on both the request and the result side.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  logic             s,
    input  logic [3:0]       flag_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flag_out,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CNT_W = $clog2(STEP + 1);
    // rem holds up to WIDTH+1 (the saturated linear shift count).
    localparam int REM_W = $clog2(WIDTH + 2);
    localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] work;
    logic             carry_q;
    logic             s_q;
    logic [3:0]       flags_q;
    logic [REM_W-1:0] rem;

    logic [31:0]      amt_ext;
    logic [31:0]      eff;
    logic [CNT_W-1:0] n_step;
    logic             last;
    logic [WIDTH-1:0] step_val;
    logic             step_c;

    assign start_ready = (state == ST_IDLE);
    assign done_valid  = (state == ST_DONE);

    // Effective count: linear shifts saturate at WIDTH+1, rotates wrap mod WIDTH.
    always_comb begin
        amt_ext = 32'(amount);
        if (shift_op_t'(op) == OP_ROR)
            eff = amt_ext % WIDTH;
        else if (amt_ext > WIDTH + 1)
            eff = WIDTH + 1;
        else
            eff = amt_ext;
    end

    // Per-cycle step size and whether this pass finishes the operation.
    always_comb begin
        last   = (rem <= STEP_R);
        n_step = last ? CNT_W'(rem) : CNT_W'(STEP);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_step (
        .op        (op_q),
        .value     (work),
        .n         (n_step),
        .carry_in  (carry_q),
        .value_out (step_val),
        .carry_out (step_c)
    );

    // Control FSM: latch request, iterate the step unit, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            work     <= '0;
            carry_q  <= 1'b0;
            s_q      <= 1'b0;
            flags_q  <= '0;
            rem      <= '0;
            result   <= '0;
            flag_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        op_q    <= op;
                        work    <= operand;
                        s_q     <= s;
                        flags_q <= flag_in;
                        rem     <= REM_W'(eff);
                        // A non-zero rotate that wraps to 0 still reports the MSB as carry.
                        carry_q <= (shift_op_t'(op) == OP_ROR && amount != '0 && eff == '0)
                                   ? operand[WIDTH-1] : flag_in[FLAG_C];
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work    <= step_val;
                    carry_q <= step_c;
                    rem     <= rem - REM_W'(n_step);
                    if (last) begin
                        state    <= ST_DONE;
                        result   <= step_val;
                        flag_out <= s_q ? {step_val[WIDTH-1], (step_val == '0), step_c, flags_q[FLAG_V]}
                                        : flags_q;
                    end
                end
                ST_DONE: begin
                    if (done_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: directed cases, handshake/reset checks,
// then randomized traffic against a behavioural model.
module tb_shift_unit;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int AMT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [1:0]       op = '0;
    logic [WIDTH-1:0] operand = '0;
    logic [AMT_W-1:0] amount = '0;
    logic             s = 1'b0;
    logic [3:0]       flag_in = '0;
    logic [WIDTH-1:0] result;
    logic [3:0]       flag_out;
    logic             done_valid;
    logic             done_ready = 1'b0;

    always #5 clk = ~clk;

    shift_unit #(.WIDTH(WIDTH), .STEP(STEP), .AMT_W(AMT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .operand     (operand),
        .amount      (amount),
        .s           (s),
        .flag_in     (flag_in),
        .result      (result),
        .flag_out    (flag_out),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [3:0]       flg;
        int               lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference behaviour straight from the shift rules, applied to the raw amount.
    function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                   input int a, input logic sb, input logic [3:0] fin);
        exp_t e;
        logic [WIDTH-1:0] r, t;
        logic c;
        int k, eff;
        r = x;
        c = fin[1];
        if (a != 0) begin
            case (o)
                2'd0: if (a < WIDTH) begin
                          r = x << a; t = x >> (WIDTH - a); c = t[0];
                      end else begin
                          r = '0; c = (a == WIDTH) ? x[0] : 1'b0;
                      end
                2'd1: if (a < WIDTH) begin
                          r = x >> a; t = x >> (a - 1); c = t[0];
                      end else begin
                          r = '0; c = (a == WIDTH) ? x[WIDTH-1] : 1'b0;
                      end
                2'd2: if (a < WIDTH) begin
                          r = $signed(x) >>> a; t = x >> (a - 1); c = t[0];
                      end else begin
                          r = {WIDTH{x[WIDTH-1]}}; c = x[WIDTH-1];
                      end
                default: begin
                    k = a % WIDTH;
                    if (k == 0) r = x;
                    else r = (x >> k) | (x << (WIDTH - k));
                    c = r[WIDTH-1];
                end
            endcase
        end
        e.res = r;
        e.flg = sb ? {r[WIDTH-1], (r == '0), c, fin[0]} : fin;
        eff   = (o == 2'd3) ? a % WIDTH : ((a > WIDTH + 1) ? WIDTH + 1 : a);
        e.lat = (eff == 0) ? 1 : (eff + STEP - 1) / STEP;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer backpressure.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       done_ready = 1'b0;
            2:       done_ready = 1'b1;
            default: done_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: latency, hold stability, and result/flag comparison on transfer.
    logic             seen = 1'b0;
    int               acc_cyc = 0;
    logic [WIDTH-1:0] hold_r;
    logic [3:0]       hold_f;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (start_valid && start_ready) acc_cyc = cyc + 1;
            if (done_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 64'(cyc - acc_cyc), (q.size() > 0) ? 64'(q[0].lat) : 64'hdead);
                    hold_r = result;
                    hold_f = flag_out;
                end else begin
                    chk("hold_result", 64'(result), 64'(hold_r));
                    chk("hold_flags", 64'(flag_out), 64'(hold_f));
                end
                if (done_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("result", 64'(result), 64'(e.res));
                        chk("flag_out", 64'(flag_out), 64'(e.flg));
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input int a,
                         input logic sb, input logic [3:0] fin);
        int t;
        @(posedge clk); #1;
        op = o; operand = x; amount = AMT_W'(a); s = sb; flag_in = fin;
        start_valid = 1'b1;
        q.push_back(model(o, x, a, sb, fin));
        t = 0;
        do begin @(negedge clk); t++; end while (!start_ready && t < 300);
        if (!start_ready) chk("start_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 600) begin @(negedge clk); t++; end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int t, a;
        logic [1:0] ro;
        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_start_ready", 64'(start_ready), 64'd1);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flag_out", 64'(flag_out), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed cases.
        rdy_mode = 2;
        issue(2'd0, 32'h3, 1, 1'b1, 4'b0000);
        issue(2'd0, 32'hFFFFFFFF, 9, 1'b1, 4'b0000);
        issue(2'd2, 32'hFFFFFFFA, 4, 1'b0, 4'b1010);
        issue(2'd0, 32'h1, 32, 1'b1, 4'b0000);
        issue(2'd0, 32'h1, 40, 1'b1, 4'b0000);
        issue(2'd1, 32'h1234, 0, 1'b1, 4'b0010);
        issue(2'd3, 32'h80000001, 36, 1'b1, 4'b0000);
        issue(2'd3, 32'h80000001, 32, 1'b1, 4'b0000);
        issue(2'd1, 32'h80000000, 32, 1'b1, 4'b0001);
        issue(2'd2, 32'h80000000, 33, 1'b1, 4'b0000);
        drain();

        // Backpressure: result held, start_ready low, stray start ignored.
        rdy_mode = 1;
        issue(2'd0, 32'h3, 1, 1'b1, 4'b0000);
        t = 0;
        while (!done_valid && t < 50) begin @(negedge clk); t++; end
        chk("bp_done_valid", 64'(done_valid), 64'd1);
        @(posedge clk); #1;
        op = 2'd1; operand = 32'hABCD; amount = 8'd5; start_valid = 1'b1;
        @(negedge clk);
        chk("bp_start_ready", 64'(start_ready), 64'd0);
        @(posedge clk); #1 start_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("bp_start_ready", 64'(start_ready), 64'd0);
        end
        rdy_mode = 0;
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       a = 0;
                1:       a = WIDTH - 1 + int'($urandom_range(0, 3));
                2:       a = int'($urandom_range(1, STEP + 1));
                3:       a = 2 * WIDTH;
                default: a = int'($urandom_range(0, 255));
            endcase
            issue(ro, $urandom, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        drain();

        // Reset while shifting: in-flight op discarded.
        rdy_mode = 2;
        issue(2'd0, 32'h1, 32, 1'b1, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        q.delete();
        chk("midrst_done_valid", 64'(done_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_start_ready", 64'(start_ready), 64'd1);
        chk("midrst_flag_out", 64'(flag_out), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(2'd1, 32'hF0, 4, 1'b1, 4'b0000);
        drain();

        repeat (10) @(negedge clk);
        chk("final_queue", 64'(q.size()), 64'd0);
        chk("final_done_valid", 64'(done_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
